// File: rtl/rtc_pkg.sv
// Shared definitions for RTC consumers: register map, bit positions and
// the packed BCD mm:ss time format.
package rtc_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_ALARM  = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_TIME   = 2'd3;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQ_EN   = 2;

  localparam int STAT_PENDING = 0;
  localparam int STAT_ARMED   = 1;
  localparam int STAT_BCD_ERR = 2;
  localparam int STAT_CNT_LSB = 8;

  typedef struct packed {
    logic [3:0] min_hi;
    logic [3:0] min_lo;
    logic [3:0] sec_hi;
    logic [3:0] sec_lo;
  } mmss_t;

  function automatic logic bcd_mmss_valid(input mmss_t t);
    return (t.min_hi <= 4'd5) && (t.min_lo <= 4'd9) &&
           (t.sec_hi <= 4'd5) && (t.sec_lo <= 4'd9);
  endfunction

endpackage

// File: rtl/rtc_change_detect.sv
// Registers an RTC time value and flags the cycle on which it changes.
module rtc_change_detect #(
  parameter int W = 16
) (
  input  logic         clk_in,
  input  logic         reset_n,
  input  logic [W-1:0] value_in,
  output logic         new_tick
);

  logic [W-1:0] value_prev;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) value_prev <= '0;
    else          value_prev <= value_in;
  end

  assign new_tick = (value_in != value_prev);

endmodule

// File: rtl/rtc_alarm.sv
// Memory-mapped alarm unit: compares live RTC mm:ss against a programmable
// alarm and raises a sticky pending flag and interrupt on a match.
module rtc_alarm
  import rtc_pkg::*;
#(
  parameter logic [15:0] RESET_ALARM = 16'h0000,
  parameter int          CNT_W       = 8
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic [15:0] time_bcd_in,
  output logic        irq_out,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out
);

  logic [2:0]       ctrl_q;
  logic [15:0]      alarm_q;
  logic             pending_q;
  logic             armed_q;
  logic             bcd_err_q;
  logic [CNT_W-1:0] match_cnt_q;

  logic        new_tick;
  logic        match;
  logic [1:0]  reg_sel;
  logic        wr_ctrl, wr_alarm, clr_pending, clr_err, clr_cnt;
  logic [15:0] alarm_merged;
  logic        alarm_ok;
  logic [CNT_W-1:0] cnt_inc;
  logic [31:0] status_word;
  logic        unused_ok;

  rtc_change_detect #(.W(16)) u_change_detect (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .value_in (time_bcd_in),
    .new_tick (new_tick)
  );

  assign reg_sel  = address_in[3:2];
  assign wr_ctrl  = sel_in && (reg_sel == REG_CTRL) && write_mask_in[0];
  assign wr_alarm = sel_in && (reg_sel == REG_ALARM) && (|write_mask_in[1:0]);
  assign clr_pending = sel_in && (reg_sel == REG_STATUS) && write_mask_in[0] &&
                       write_value_in[STAT_PENDING];
  assign clr_err     = sel_in && (reg_sel == REG_STATUS) && write_mask_in[0] &&
                       write_value_in[STAT_BCD_ERR];
  assign clr_cnt     = sel_in && (reg_sel == REG_STATUS) && write_mask_in[1];

  assign alarm_merged = {write_mask_in[1] ? write_value_in[15:8] : alarm_q[15:8],
                         write_mask_in[0] ? write_value_in[7:0]  : alarm_q[7:0]};
  assign alarm_ok     = bcd_mmss_valid(mmss_t'(alarm_merged));

  // Gating on new_tick makes the match a single-cycle event per RTC second.
  assign match   = armed_q && new_tick && (time_bcd_in == alarm_q);
  assign cnt_inc = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + 1'b1;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q    <= '0;
      alarm_q   <= RESET_ALARM;
      bcd_err_q <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= write_value_in[2:0];
      if (wr_alarm) begin
        if (alarm_ok) alarm_q   <= alarm_merged;
        else          bcd_err_q <= 1'b1;
      end else if (clr_err) begin
        bcd_err_q <= 1'b0;
      end
    end
  end

  // A match takes priority over software clears so no event is lost.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      pending_q   <= 1'b0;
      armed_q     <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      if (match)            pending_q <= 1'b1;
      else if (clr_pending) pending_q <= 1'b0;

      if (match && !ctrl_q[CTRL_PERIODIC]) armed_q <= 1'b0;
      else if (wr_ctrl)                    armed_q <= write_value_in[CTRL_ENABLE];

      if (match)        match_cnt_q <= clr_cnt ? CNT_W'(1) : cnt_inc;
      else if (clr_cnt) match_cnt_q <= '0;
    end
  end

  always_comb begin
    status_word = '0;
    status_word[STAT_PENDING] = pending_q;
    status_word[STAT_ARMED]   = armed_q;
    status_word[STAT_BCD_ERR] = bcd_err_q;
    status_word[STAT_CNT_LSB +: CNT_W] = match_cnt_q;
  end

  always_comb begin
    read_value_out = '0;
    if (sel_in) begin
      case (reg_sel)
        REG_CTRL:   read_value_out = {29'b0, ctrl_q};
        REG_ALARM:  read_value_out = {16'b0, alarm_q};
        REG_STATUS: read_value_out = status_word;
        default:    read_value_out = {16'b0, time_bcd_in};
      endcase
    end
  end

  assign irq_out   = pending_q && ctrl_q[CTRL_IRQ_EN];
  assign ready_out = sel_in;

  assign unused_ok = ^{address_in[31:4], address_in[1:0], write_mask_in[3:2],
                       write_value_in[31:16]};

endmodule

// File: tb/tb_rtc_alarm.sv
// Directed self-checking bench for rtc_alarm with hand-computed expectations.
module tb_rtc_alarm;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic [15:0] time_bcd_in;
  logic        irq_out;
  logic [31:0] address_in;
  logic        sel_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd;

  localparam logic [31:0] A_CTRL   = 32'h0;
  localparam logic [31:0] A_ALARM  = 32'h4;
  localparam logic [31:0] A_STATUS = 32'h8;
  localparam logic [31:0] A_TIME   = 32'hC;

  rtc_alarm #(.RESET_ALARM(16'h0000), .CNT_W(8)) dut (
    .clk_in         (clk_in),
    .reset_n        (reset_n),
    .time_bcd_in    (time_bcd_in),
    .irq_out        (irq_out),
    .address_in     (address_in),
    .sel_in         (sel_in),
    .read_value_out (read_value_out),
    .write_mask_in  (write_mask_in),
    .write_value_in (write_value_in),
    .ready_out      (ready_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] mask,
                               input logic [31:0] data);
    @(negedge clk_in);
    sel_in = 1'b1; address_in = addr; write_mask_in = mask; write_value_in = data;
    @(negedge clk_in);
    sel_in = 1'b0; write_mask_in = 4'b0; write_value_in = '0;
  endtask

  task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk_in);
    sel_in = 1'b1; address_in = addr; write_mask_in = 4'b0;
    #1 data = read_value_out;
    sel_in = 1'b0;
  endtask

  task automatic setTime(input logic [15:0] t, input int settle);
    @(negedge clk_in);
    time_bcd_in = t;
    repeat (settle) @(negedge clk_in);
  endtask

  initial begin
    reset_n = 1'b0; time_bcd_in = 16'h0000; sel_in = 1'b0;
    address_in = '0; write_mask_in = '0; write_value_in = '0;
    repeat (3) @(negedge clk_in);
    #1;
    checkOutput("rst_irq", {31'b0, irq_out}, 32'h0);
    checkOutput("rst_rdata_nosel", read_value_out, 32'h0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk_in);
    busRead(A_CTRL, rd);   checkOutput("rst_ctrl", rd, 32'h0);
    busRead(A_ALARM, rd);  checkOutput("rst_alarm", rd, 32'h0);
    busRead(A_STATUS, rd); checkOutput("rst_status", rd, 32'h0);
    busRead(A_TIME, rd);   checkOutput("rst_time", rd, 32'h0);

    // One-shot alarm
    applyStimulus(A_ALARM, 4'b0011, 32'h0000_0102);
    setTime(16'h0101, 2);
    applyStimulus(A_CTRL, 4'b0001, 32'h5);
    busRead(A_STATUS, rd); checkOutput("armed_set", rd, 32'h0000_0002);
    busRead(A_TIME, rd);   checkOutput("time_read", rd, 32'h0000_0101);
    setTime(16'h0102, 1);
    #1 checkOutput("oneshot_irq", {31'b0, irq_out}, 32'h1);
    busRead(A_STATUS, rd); checkOutput("oneshot_status", rd, 32'h0000_0101);
    repeat (1000) @(negedge clk_in);
    busRead(A_STATUS, rd); checkOutput("oneshot_hold", rd, 32'h0000_0101);
    applyStimulus(A_STATUS, 4'b0011, 32'h0000_0001);
    busRead(A_STATUS, rd); checkOutput("w1c_clear", rd, 32'h0);
    #1 checkOutput("irq_cleared", {31'b0, irq_out}, 32'h0);

    // Periodic alarm, second match collides with pending W1C
    setTime(16'h0029, 2);
    applyStimulus(A_ALARM, 4'b0011, 32'h0000_0030);
    applyStimulus(A_CTRL, 4'b0001, 32'h7);
    setTime(16'h0030, 1);
    busRead(A_STATUS, rd); checkOutput("periodic_first", rd, 32'h0000_0103);
    setTime(16'h0029, 2);
    @(negedge clk_in);
    time_bcd_in = 16'h0030;
    sel_in = 1'b1; address_in = A_STATUS; write_mask_in = 4'b0001; write_value_in = 32'h1;
    @(negedge clk_in);
    sel_in = 1'b0; write_mask_in = 4'b0;
    busRead(A_STATUS, rd); checkOutput("periodic_w1c_conflict", rd, 32'h0000_0203);
    applyStimulus(A_CTRL, 4'b0001, 32'h3);
    #1 checkOutput("irq_masked", {31'b0, irq_out}, 32'h0);
    busRead(A_STATUS, rd); checkOutput("pending_kept", rd, 32'h0000_0203);

    // BCD validation
    applyStimulus(A_ALARM, 4'b0011, 32'h0000_0A00);
    busRead(A_ALARM, rd);  checkOutput("bad_lo_digit_alarm", rd, 32'h0000_0030);
    busRead(A_STATUS, rd); checkOutput("bad_lo_digit_err", rd, 32'h0000_0207);
    applyStimulus(A_STATUS, 4'b0001, 32'h4);
    busRead(A_STATUS, rd); checkOutput("err_w1c", rd, 32'h0000_0203);
    applyStimulus(A_ALARM, 4'b0011, 32'h0000_6000);
    busRead(A_ALARM, rd);  checkOutput("bad_hi_digit_alarm", rd, 32'h0000_0030);
    busRead(A_STATUS, rd); checkOutput("bad_hi_digit_err", rd, 32'h0000_0207);
    applyStimulus(A_ALARM, 4'b0011, 32'h0000_5959);
    busRead(A_ALARM, rd);  checkOutput("max_valid", rd, 32'h0000_5959);

    // Byte-masked write and deselected write
    applyStimulus(A_ALARM, 4'b0011, 32'h0000_1230);
    applyStimulus(A_ALARM, 4'b0001, 32'h0000_0045);
    busRead(A_ALARM, rd);  checkOutput("byte_mask", rd, 32'h0000_1245);
    @(negedge clk_in);
    address_in = A_ALARM; write_mask_in = 4'b1111; write_value_in = 32'h0000_0000;
    #1;
    checkOutput("nosel_rdata", read_value_out, 32'h0);
    checkOutput("nosel_ready", {31'b0, ready_out}, 32'h0);
    @(negedge clk_in);
    write_mask_in = 4'b0;
    busRead(A_ALARM, rd);  checkOutput("nosel_nowrite", rd, 32'h0000_1245);

    // Counter saturation with periodic repeats
    applyStimulus(A_STATUS, 4'b0011, 32'h0000_0005);
    applyStimulus(A_ALARM, 4'b0011, 32'h0000_0030);
    applyStimulus(A_CTRL, 4'b0001, 32'h7);
    for (int i = 0; i < 300; i++) begin
      setTime(16'h0029, 1);
      setTime(16'h0030, 1);
    end
    busRead(A_STATUS, rd); checkOutput("cnt_saturate", rd, 32'h0000_FF03);

    // Match coincides with counter clear
    setTime(16'h0029, 2);
    @(negedge clk_in);
    time_bcd_in = 16'h0030;
    sel_in = 1'b1; address_in = A_STATUS; write_mask_in = 4'b0010; write_value_in = 32'h0;
    @(negedge clk_in);
    sel_in = 1'b0; write_mask_in = 4'b0;
    busRead(A_STATUS, rd); checkOutput("cnt_clear_conflict", rd, 32'h0000_0103);

    // Match coincides with disable write
    setTime(16'h0029, 2);
    @(negedge clk_in);
    time_bcd_in = 16'h0030;
    sel_in = 1'b1; address_in = A_CTRL; write_mask_in = 4'b0001; write_value_in = 32'h4;
    @(negedge clk_in);
    sel_in = 1'b0; write_mask_in = 4'b0;
    busRead(A_STATUS, rd); checkOutput("disable_conflict", rd, 32'h0000_0201);
    #1 checkOutput("irq_before_reset", {31'b0, irq_out}, 32'h1);

    // Asynchronous reset between edges
    @(posedge clk_in);
    #3 reset_n = 1'b0;
    #1 checkOutput("async_irq_drop", {31'b0, irq_out}, 32'h0);
    checkOutput("async_rdata_nosel", read_value_out, 32'h0);
    #3 reset_n = 1'b1;
    busRead(A_CTRL, rd);   checkOutput("post_rst_ctrl", rd, 32'h0);
    busRead(A_ALARM, rd);  checkOutput("post_rst_alarm", rd, 32'h0);
    busRead(A_STATUS, rd); checkOutput("post_rst_status", rd, 32'h0);
    busRead(A_TIME, rd);   checkOutput("post_rst_time", rd, 32'h0000_0030);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
